// File: rtl/mux2t1_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux, with registered grants
// and a hold limit that bounds how long one side keeps the datapath while the other waits.
module mux2t1_arbiter #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] o,
  output logic             valid
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGntA = 2'd1;
  localparam logic [1:0] StGntB = 2'd2;

  localparam logic [3:0] CntMax = 4'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_b_q, last_b_d;
  logic       sel_q, sel_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = last_b_q ? StGntA : StGntB;
        end else if (req_a) begin
          state_d = StGntA;
        end else if (req_b) begin
          state_d = StGntB;
        end
      end
      StGntA: begin
        if (!req_a) begin
          state_d = req_b ? StGntB : StIdle;
        end else if (req_b && (cnt_q == CntMax)) begin
          state_d = StGntB;
        end
      end
      StGntB: begin
        if (!req_b) begin
          state_d = req_a ? StGntA : StIdle;
        end else if (req_a && (cnt_q == CntMax)) begin
          state_d = StGntA;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter saturates so a lone holder is never pre-empted.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q != StIdle) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    last_b_d = last_b_q;
    sel_d    = sel_q;
    if (state_d == StGntA) begin
      last_b_d = 1'b0;
      sel_d    = 1'b0;
    end else if (state_d == StGntB) begin
      last_b_d = 1'b1;
      sel_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
    end
  end

  assign gnt_a = (state_q == StGntA);
  assign gnt_b = (state_q == StGntB);
  assign valid = gnt_a | gnt_b;
  assign sel   = sel_q;
  assign o     = valid ? (sel_q ? b : a) : '0;

endmodule

// File: tb/tb_mux2t1_arbiter.sv
// Vector-table bench for mux2t1_arbiter: expected outputs queued at drive time and
// compared one cycle later; a second instance covers the HOLD_MAX=1 corner.
module tb_mux2t1_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_a, req_b, a, b;
  logic gnt_a, gnt_b, sel, o, valid;
  logic gnt_a1, gnt_b1, sel1, o1, valid1;

  mux2t1_arbiter #(.WIDTH(1), .HOLD_MAX(4)) u_dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .o(o), .valid(valid)
  );

  mux2t1_arbiter #(.WIDTH(1), .HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .o(o1), .valid(valid1)
  );

  // exp packs {gnt_a, gnt_b, sel, valid, o}
  typedef struct packed {
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       a;
    logic       b;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic void add(input logic [9:0] bits);
    vecs.push_back(vec_t'(bits));
  endfunction

  task automatic check(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s[%0d]: got {ga,gb,sel,v,o}=%b, expected %b", name, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst   = v.rst;
    req_a = v.req_a;
    req_b = v.req_b;
    a     = v.a;
    b     = v.b;
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 1'b0; b = 1'b0;

    //   rst ra rb a b _ ga gb sel v o
    add(10'b11111_00000);  // reset with requests held
    add(10'b11111_00000);
    add(10'b01010_10011);  // lone A, a toggling
    add(10'b01000_10010);
    add(10'b01010_10011);
    add(10'b01001_10010);
    add(10'b01010_10011);  // counter saturated, still A
    add(10'b01000_10010);
    add(10'b00011_00000);  // A drops
    add(10'b10000_00000);  // reset so last-served is B
    add(10'b01110_10011);  // tie from idle -> A
    add(10'b01110_10011);
    add(10'b01110_10011);
    add(10'b01110_10011);
    add(10'b01110_01110);  // hold limit hit -> B, no gap
    add(10'b01110_01110);
    add(10'b01110_01110);
    add(10'b01110_01110);
    add(10'b01110_10011);  // back to A
    add(10'b01110_10011);
    add(10'b01110_10011);
    add(10'b01110_10011);
    add(10'b01110_01110);
    add(10'b01101_01111);
    add(10'b01011_10011);  // B releases, A granted next edge
    add(10'b00101_01111);  // A releases, B granted
    add(10'b00011_00100);  // idle, sel holds 1
    add(10'b00101_01111);  // B alone, cnt 0
    add(10'b01101_01111);  // cnt 1
    add(10'b01101_01111);  // cnt 2
    add(10'b11111_00000);  // reset mid-grant
    add(10'b01110_10011);  // A wins after reset
    add(10'b00011_00000);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check("vec", i, {gnt_a, gnt_b, sel, valid, o}, exp_q.pop_front());
    end

    // HOLD_MAX=1: alternate every cycle under contention, lone holder keeps grant
    drive(vec_t'(10'b11111_00000));
    exp_q.push_back(5'b00000);
    @(posedge clk);
    #1;
    check("hm1_rst", 0, {gnt_a1, gnt_b1, sel1, valid1, o1}, exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(vec_t'({i < 5 ? 5'b01110 : 5'b01010, 5'b00000}));
      if (i < 5) exp_q.push_back((i % 2 == 0) ? 5'b10011 : 5'b01110);
      else       exp_q.push_back(5'b10011);
      @(posedge clk);
      #1;
      check("hm1_alt", i, {gnt_a1, gnt_b1, sel1, valid1, o1}, exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  always @(posedge clk) begin
    #1;
    if (gnt_a && gnt_b) begin
      n_err++;
      $display("FAIL overlap: got gnt_a=1 gnt_b=1, expected at most one grant");
    end
  end

endmodule
